// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: pipeline stall request and hold/bubble control bundle
interface stall_ctrl_if;
  logic        id_stallreq_i;
  logic        exe_div_start_i;
  logic        mem_stallreq_i;
  logic        flush_i;
  logic [4:0]  stall_o;
  logic [4:0]  bubble_o;
  logic        div_busy_o;
  logic        div_done_o;
  logic [31:0] stall_cnt_o;
  modport master (
    output id_stallreq_i, exe_div_start_i, mem_stallreq_i, flush_i,
    input  stall_o, bubble_o, div_busy_o, div_done_o, stall_cnt_o
  );
  modport slave (
    input  id_stallreq_i, exe_div_start_i, mem_stallreq_i, flush_i,
    output stall_o, bubble_o, div_busy_o, div_done_o, stall_cnt_o
  );
endinterface

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall/bubble resolution and fixed-latency divide sequencer; STALL_CTRL_PERF_EN adds a stalled-cycle counter
module stall_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input logic         clk,
  input logic         rst,
  stall_ctrl_if.slave bus
);
  localparam int CW = $clog2(DIV_CYCLES);
  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} state_t;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          exe_req;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE:     if (bus.exe_div_start_i) begin
                  state_nx = DIV_RUN;
                  cnt_nx   = CW'(DIV_CYCLES - 1);
                end
      DIV_RUN:  if (cnt == CW'(1)) state_nx = DIV_DONE;
                else cnt_nx = cnt - CW'(1);
      DIV_DONE: if (!bus.mem_stallreq_i) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (bus.flush_i) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end
  end
  // the start cycle itself already stalls, so the request spans exactly DIV_CYCLES cycles
  assign exe_req = (state == IDLE && bus.exe_div_start_i) || state == DIV_RUN;
  assign bus.stall_o = rst                ? 5'b00000 :
                       bus.flush_i        ? 5'b00000 :
                       bus.mem_stallreq_i ? 5'b01111 :
                       exe_req            ? 5'b00111 :
                       bus.id_stallreq_i  ? 5'b00011 : 5'b00000;
  assign bus.bubble_o = rst                ? 5'b00000 :
                        bus.flush_i        ? 5'b01110 :
                        bus.mem_stallreq_i ? 5'b10000 :
                        exe_req            ? 5'b01000 :
                        bus.id_stallreq_i  ? 5'b00100 : 5'b00000;
  assign bus.div_busy_o = state == DIV_RUN;
  assign bus.div_done_o = state == DIV_DONE;
`ifdef STALL_CTRL_PERF_EN
  logic [31:0] perf_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) perf_cnt <= '0;
    else if (bus.stall_o[0] && perf_cnt != 32'hFFFF_FFFF) perf_cnt <= perf_cnt + 32'd1;
  assign bus.stall_cnt_o = perf_cnt;
`else
  assign bus.stall_cnt_o = 32'h0;
`endif
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed scenarios with a queued scoreboard checked once per cycle on the falling edge
module tb_stall_ctrl;
`ifdef STALL_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    string       nm;
    logic [4:0]  s;
    logic [4:0]  b;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  stall_ctrl_if bus ();
  stall_ctrl #(.DIV_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic push(input string nm, input logic [4:0] s, input logic [4:0] b,
                      input logic busy, input logic done, input int c);
    exp_t e;
    e.nm = nm; e.s = s; e.b = b; e.busy = busy; e.done = done;
    e.cnt = PERF ? 32'(c) : 32'h0;
    exp_q.push_back(e);
  endtask
  task automatic drive(input logic id, input logic st, input logic mem, input logic fl);
    bus.id_stallreq_i   = id;
    bus.exe_div_start_i = st;
    bus.mem_stallreq_i  = mem;
    bus.flush_i         = fl;
  endtask
  task automatic cyc(input string nm, input logic id, input logic st, input logic mem, input logic fl,
                     input logic [4:0] s, input logic [4:0] b, input logic busy, input logic done, input int c);
    drive(id, st, mem, fl);
    push(nm, s, b, busy, done, c);
    @(posedge clk); #1;
  endtask
  task automatic async_reset(input string nm, input logic hi);
    drive(hi, hi, hi, hi);
    #1 rst = 1'b1;
    push(nm, 5'b00000, 5'b00000, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0);
    rst = 1'b0;
  endtask
  always @(negedge clk)
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (bus.stall_o !== e.s || bus.bubble_o !== e.b || bus.div_busy_o !== e.busy ||
          bus.div_done_o !== e.done || bus.stall_cnt_o !== e.cnt) begin
        fails++;
        $display("FAIL %s: got stall=%b bubble=%b busy=%b done=%b cnt=%0d, want stall=%b bubble=%b busy=%b done=%b cnt=%0d",
                 e.nm, bus.stall_o, bus.bubble_o, bus.div_busy_o, bus.div_done_o, bus.stall_cnt_o,
                 e.s, e.b, e.busy, e.done, e.cnt);
      end
    end
  initial begin
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    async_reset("reset_all_high", 1'b1);
    cyc("post_reset_idle", 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
    cyc("load_use",        1, 0, 0, 0, 5'b00011, 5'b00100, 0, 0, 0);
    cyc("load_use_clear",  0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 1);
    cyc("div_start",       0, 1, 0, 0, 5'b00111, 5'b01000, 0, 0, 1);
    cyc("div_run1",        0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 2);
    cyc("div_run2",        0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 3);
    cyc("div_run3",        0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 4);
    cyc("div_done",        0, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 5);
    cyc("div_idle",        0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 5);
    cyc("mw_start",        0, 1, 0, 0, 5'b00111, 5'b01000, 0, 0, 5);
    cyc("mw_run1",         0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 6);
    cyc("mw_run2",         0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 7);
    cyc("mw_run3_mem",     0, 0, 1, 0, 5'b01111, 5'b10000, 1, 0, 8);
    cyc("mw_done_mem1",    0, 1, 1, 0, 5'b01111, 5'b10000, 0, 1, 9);
    cyc("mw_done_mem2",    0, 1, 1, 0, 5'b01111, 5'b10000, 0, 1, 10);
    cyc("mw_done_mem3",    0, 1, 1, 0, 5'b01111, 5'b10000, 0, 1, 11);
    cyc("mw_done_release", 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 12);
    cyc("mw_idle",         0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 12);
    cyc("fl_start",        0, 1, 0, 0, 5'b00111, 5'b01000, 0, 0, 12);
    cyc("fl_run1",         0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 13);
    cyc("fl_run2_flush",   0, 0, 0, 1, 5'b00000, 5'b01110, 1, 0, 14);
    cyc("fl_idle",         0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 14);
    cyc("start_and_flush", 0, 1, 0, 1, 5'b00000, 5'b01110, 0, 0, 14);
    cyc("no_transition",   0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 14);
    cyc("id_with_div",     1, 1, 0, 0, 5'b00111, 5'b01000, 0, 0, 14);
    cyc("id_div_flush",    1, 0, 0, 1, 5'b00000, 5'b01110, 1, 0, 15);
    cyc("id_div_idle",     0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 15);
    cyc("rd_start",        0, 1, 0, 0, 5'b00111, 5'b01000, 0, 0, 15);
    cyc("rd_run1",         0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 16);
    async_reset("reset_mid_div", 1'b0);
    cyc("rd_restart",      0, 1, 0, 0, 5'b00111, 5'b01000, 0, 0, 0);
    cyc("rd_run1b",        0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 1);
    cyc("rd_run2b",        0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 2);
    cyc("rd_run3b",        0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 3);
    cyc("rd_done",         0, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 4);
    cyc("rd_idle",         0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 4);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Central pipeline stall/bubble controller for the five-stage core. Collects stall requests from ID (load-use), EXE (multi-cycle divide, sequenced internally), and MEM (data bus wait), plus a pipeline flush. Produces per-register hold (`stall_o`) and insert-nop (`bubble_o`) controls for the PC, if2id, id2exe, exe2mem and mem2wb registers. It owns the divide-busy sequencer that stretches an EXE-stage DIV/DIVU to a fixed latency.

## Interface
- `DIV_CYCLES`, default 32: number of consecutive cycles EXE is stalled for one divide. Legal range is 2..255.
- `rst`  in  1  asynchronous, active-high reset.
- `clk`  in  1  single clock; all state updates on posedge.
- `id_stallreq_i`  in  1  load-use hazard detected in ID; combinational, same cycle.
- `exe_div_start_i`  in  1  EXE holds a DIV/DIVU not yet started.
- `mem_stallreq_i`  in  1  data memory not ready.
- `flush_i`  in  1  exception/redirect flush; highest priority.
- `stall_o`  out  5  hold controls: [0] pc, [1] if2id, [2] id2exe, [3] exe2mem, [4] mem2wb.
- `bubble_o`  out  5  same bit order; the register loads all-zero (nop) this cycle.
- `div_busy_o`  out  1  divider sequencer in DIV_RUN.
- `div_done_o`  out  1  divide result valid in EXE; captured by exe2mem when not stalled.
- `stall_cnt_o`  out  32  performance count of stalled cycles (see Configuration).

## Operation
- **Divide FSM states:** IDLE, DIV_RUN, DIV_DONE. It uses an internal down-counter `cnt` of width ceil(log2(DIV_CYCLES)).
- **IDLE:**
  - `exe_div_start_i` & !`flush_i` → DIV_RUN, `cnt` <= DIV_CYCLES-1.
  - The exe request is asserted in this start cycle.
- **DIV_RUN:**
  - The exe request is asserted.
  - `cnt`==1 → DIV_DONE; otherwise `cnt` <= `cnt`-1.
  - The counter decrements regardless of `mem_stallreq_i`.
- **DIV_DONE:**
  - `div_done_o`=1 and the exe request is deasserted.
  - `mem_stallreq_i`=0 → IDLE. `mem_stallreq_i`=1 → stay in DIV_DONE, holding `div_done_o`.
  - `exe_div_start_i` is ignored in DIV_DONE, since the same instruction is still in EXE.
- **Divide stall length:** the exe request is high for exactly DIV_CYCLES consecutive cycles per divide.
- **Flush:** `flush_i` in any state → IDLE and `cnt` <= 0 next edge.
- **Stall resolution:** combinational; the deepest requester wins.
  - `mem_stallreq_i`: `stall_o`=01111, `bubble_o`=10000.
  - Else exe request: `stall_o`=00111, `bubble_o`=01000.
  - Else `id_stallreq_i`: `stall_o`=00011, `bubble_o`=00100.
  - Else: `stall_o`=00000, `bubble_o`=00000.
- **`flush_i`=1 overrides all requests:** `stall_o`=00000 (the PC loads the redirect) and `bubble_o`=01110.
- **Invariant:** a bit is never set in both `stall_o` and `bubble_o`.
- **`div_busy_o`** = (state==DIV_RUN).

## Timing
- **Latency:** `stall_o`, `bubble_o` and `div_done_o` are combinational from the inputs and registered state, with zero-cycle latency. This is required so the pipeline registers hold in the same cycle the request rises.
- **State changes:** FSM and counter change only on posedge `clk`, or asynchronously on `rst`.
- **Reset values:** while `rst`=1, the block forces the following.
  - State IDLE, `cnt`=0.
  - `stall_o`=0, `bubble_o`=0.
  - `div_busy_o`=0, `div_done_o`=0, `stall_cnt_o`=0.
- **Reset mid-divide:** the sequence is abandoned. After deassertion the block sits in IDLE and a new `exe_div_start_i` restarts a full DIV_CYCLES stall.
- **Simultaneous `exe_div_start_i` and `flush_i` in IDLE:** no transition, and the flush outputs apply.
- **Simultaneous `id_stallreq_i` and a divide:** the exe pattern is driven, and ID stays stalled because it is upstream.

## Configuration
- **Macro:** `STALL_CTRL_PERF_EN`.
- **Defined:** `stall_cnt_o` increments by 1 on every posedge where `stall_o[0]`=1 and `rst`=0.
  - It saturates at 32'hFFFF_FFFF and is cleared only by `rst`.
- **Undefined:** `stall_cnt_o` is tied to 32'h0 and no counter flops are synthesized. The port list is unchanged.

## Test plan
1. **Reset:** assert `rst` asynchronously mid-cycle with all requests high → all outputs 0 immediately. After release with no requests → `stall_o`=00000, `bubble_o`=00000.
2. **Load-use:** `id_stallreq_i`=1 for one cycle → that cycle `stall_o`=00011, `bubble_o`=00100. Next cycle both are 0.
3. **Divide, DIV_CYCLES=4:** pulse `exe_div_start_i` → `stall_o`=00111 and `bubble_o`=01000 for exactly 4 cycles. `div_busy_o` is high for the last 3 of them. The 5th cycle has `div_done_o`=1 and `stall_o`=0, then the FSM returns to IDLE.
4. **MEM wait over divide done:** DIV_CYCLES=4, with `mem_stallreq_i`=1 for 3 cycles starting at the DIV_DONE cycle → `div_done_o` held for 3 cycles with `stall_o`=01111 and `bubble_o`=10000. Then IDLE.
5. **Flush mid-divide:** `flush_i`=1 in the second DIV_RUN cycle → that cycle `stall_o`=00000, `bubble_o`=01110. Next cycle the FSM is in IDLE and `div_busy_o`=0.
6. **Performance counter (`STALL_CTRL_PERF_EN` defined):** after scenarios 2 and 3 → `stall_cnt_o`=5. Undefined → `stall_cnt_o`=0 throughout.
